// File: rtl/series_dp_scheduler.sv
// Round-robin front end sharing one series engine among NREQ clients.
// Grants one job at a time, runs the engine handshake, returns result or timeout.
module series_dp_scheduler #(
  parameter int W       = 16,
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] x_in,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              dp_start,
  output logic [1:0]        dp_func,
  output logic [W-1:0]      dp_x,
  input  logic              dp_done,
  input  logic [W-1:0]      dp_result
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, GRANT, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND
  } state_t;

  state_t        state, nxt;
  logic [1:0]    ptr, g, pick;
  logic [2:0]    idx;
  logic          found;
  logic          expired;
  logic [TW-1:0] tcnt;
  logic [NREQ-1:0] g_hot;

  // first set request at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + 3'(i);
      if (idx >= 3'(NREQ))
        idx = idx - 3'(NREQ);
      if (!found && req[idx[1:0]]) begin
        found = 1'b1;
        pick  = idx[1:0];
      end
    end
  end

  always_comb begin
    nxt     = state;
    expired = (tcnt >= TW'(TIMEOUT - 1));
    case (state)
      IDLE:      if (found && dp_done) nxt = GRANT;
      GRANT:     nxt = ISSUE;
      ISSUE:     nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!dp_done)     nxt = WAIT_DONE;
        else if (expired) nxt = RESPOND;
      end
      WAIT_DONE: if (dp_done || expired) nxt = RESPOND;
      RESPOND:   nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    g_hot    = '0;
    g_hot[g] = 1'b1;
  end

  assign busy      = (state != IDLE);
  assign dp_start  = (state == ISSUE);
  assign ack       = (state == GRANT)   ? g_hot : '0;
  assign rsp_valid = (state == RESPOND) ? g_hot : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      g        <= '0;
      tcnt     <= '0;
      dp_x     <= '0;
      dp_func  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (nxt == GRANT) begin
            g       <= pick;
            dp_x    <= x_in[pick*W +: W];
            dp_func <= pick;
          end
        end
        ISSUE: tcnt <= '0;
        WAIT_BUSY, WAIT_DONE: begin
          tcnt <= tcnt + 1'b1;
          if (state == WAIT_DONE && dp_done) begin
            rsp_data <= dp_result;
            rsp_err  <= 1'b0;
          end else if (nxt == RESPOND) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        RESPOND: ptr <= (g == 2'(NREQ - 1)) ? 2'd0 : g + 2'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_series_dp_scheduler.sv
// Directed bench for series_dp_scheduler with a behavioural series engine.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_series_dp_scheduler;
  localparam int W       = 16;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] x_in;
  logic [NREQ-1:0]   ack, rsp_valid;
  logic [W-1:0]      rsp_data, dp_x, dp_result;
  logic              rsp_err, busy, dp_start, dp_done;
  logic [1:0]        dp_func;

  logic dp_done_eng, force_low, hang;
  int   run_len;
  assign dp_done = dp_done_eng & ~force_low;

  series_dp_scheduler #(.W(W), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .dp_start(dp_start),
    .dp_func(dp_func), .dp_x(dp_x), .dp_done(dp_done),
    .dp_result(dp_result)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc = 0;
  int rsp_cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // engine: drops done after start, runs run_len cycles, returns 3x+func+1
  logic [W-1:0] e_x;
  logic [1:0]   e_f;
  int           e_cnt;
  logic         e_run;
  always @(posedge clk) begin
    if (rst) begin
      dp_done_eng <= 1'b1;
      dp_result   <= '0;
      e_run       <= 1'b0;
      e_cnt       <= 0;
    end else if (e_run) begin
      if (e_cnt <= 1) begin
        e_run       <= 1'b0;
        dp_done_eng <= 1'b1;
        dp_result   <= e_x * 16'd3 + {14'd0, e_f} + 16'd1;
      end else begin
        e_cnt <= e_cnt - 1;
      end
    end else if (dp_start && !hang) begin
      e_run       <= 1'b1;
      dp_done_eng <= 1'b0;
      e_cnt       <= run_len;
      e_x         <= dp_x;
      e_f         <= dp_func;
    end
  end

  typedef struct {
    int           idx;
    logic [W-1:0] d;
    logic         e;
  } exp_t;
  exp_t q[$];

  task automatic push(input int idx, input logic [W-1:0] d, input logic e);
    exp_t t;
    t.idx = idx;
    t.d   = d;
    t.e   = e;
    q.push_back(t);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dp_start) start_cyc = cyc;
      if (|ack || |rsp_valid || dp_start) begin
        n_tests++;
        if ($countones({ack, rsp_valid, dp_start}) != 1) begin
          n_fail++;
          $display("FAIL exclusive: ack=%b rsp_valid=%b dp_start=%b required one-hot",
                   ack, rsp_valid, dp_start);
        end
      end
      if (|rsp_valid) begin
        rsp_cyc = cyc;
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=%b required none", rsp_valid);
        end else begin
          exp_t t;
          t = q.pop_front();
          if (rsp_valid !== (NREQ'(1) << t.idx) || rsp_data !== t.d ||
              rsp_err !== t.e) begin
            n_fail++;
            $display("FAIL rsp: got v=%b d=%h e=%b required v=%b d=%h e=%b",
                     rsp_valid, rsp_data, rsp_err, NREQ'(1) << t.idx, t.d, t.e);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] a);
    a = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (|ack) begin
        a = ack;
        return;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) break;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [NREQ-1:0] a;
  logic [NREQ-1:0] order [4];
  logic            seen;

  initial begin
    rst = 1'b1; req = '0; x_in = '0;
    force_low = 1'b0; hang = 1'b0; run_len = 20;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_dp_x", dp_x, 0);
    check("rst_rsp_data", rsp_data, 0);
    rst = 1'b0;

    // single job, minimum latency
    x_in = {16'h0, 16'h0, 16'h1000};
    req  = 3'b001;
    @(negedge clk);
    check("t1_ack", ack, 3'b001);
    check("t1_start_early", dp_start, 0);
    push(0, 16'h3001, 1'b0);
    req = '0;
    @(negedge clk);
    check("t1_start", dp_start, 1);
    check("t1_func", dp_func, 0);
    check("t1_dp_x", dp_x, 16'h1000);
    drain();

    // round robin with all requesting
    do_reset();
    order[0] = 3'b001; order[1] = 3'b010;
    order[2] = 3'b100; order[3] = 3'b001;
    x_in = {16'h0030, 16'h0020, 16'h0010};
    req  = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(a);
      check($sformatf("t2_ack%0d", k), a, order[k]);
      if (k == 1)      push(1, 16'h0062, 1'b0);
      else if (k == 2) push(2, 16'h0093, 1'b0);
      else             push(0, 16'h0031, 1'b0);
      if (k == 3) req = '0;
    end
    drain();

    // engine hang -> timeout, then a normal job
    hang = 1'b1;
    req  = 3'b001;
    wait_ack(a);
    check("t3_ack", a, 3'b001);
    push(0, 16'h0000, 1'b1);
    req = '0;
    drain();
    check("t3_latency", rsp_cyc - start_cyc, TIMEOUT + 1);
    hang = 1'b0;
    req  = 3'b010;
    wait_ack(a);
    check("t3_next_ack", a, 3'b010);
    push(1, 16'h0062, 1'b0);
    req = '0;
    drain();

    // engine not idle blocks grant
    force_low = 1'b1;
    x_in = {16'h0, 16'h0100, 16'h0};
    req  = 3'b010;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (|ack) seen = 1'b1;
    end
    check("t4_blocked", seen, 0);
    force_low = 1'b0;
    @(negedge clk);
    check("t4_ack", ack, 3'b010);
    push(1, 16'h0302, 1'b0);
    req = '0;
    drain();

    // reset during WAIT_DONE drops the job
    req = 3'b010;
    wait_ack(a);
    check("t5_ack", a, 3'b010);
    req = '0;
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("t5_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_outs", {ack, rsp_valid, dp_start, rsp_err}, 0);
    check("t5_dp_x", dp_x, 0);
    check("t5_func", dp_func, 0);
    check("t5_rsp_data", rsp_data, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    x_in = {16'h0300, 16'h0, 16'h0200};
    req  = 3'b101;
    wait_ack(a);
    check("t5_ptr0", a, 3'b001);
    push(0, 16'h0601, 1'b0);
    req = '0;
    drain();

    // request withdrawn after sampling still completes
    x_in = {16'h0400, 16'h0, 16'h0005};
    req  = 3'b100;
    @(negedge clk);
    check("t6_ack", ack, 3'b100);
    req = '0;
    push(2, 16'h0C03, 1'b0);
    drain();
    req = 3'b011;
    wait_ack(a);
    check("t6_ptr_wrap", a, 3'b001);
    push(0, 16'h0010, 1'b0);
    req = '0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
